// File: rtl/jtopl_dac_pkg.sv
// Shared constants for the serial floating-point DAC transmitter.
// Frame: 16 bit slots, LSB first. Slots 0-2 are zero padding, slots 3-12
// carry the 10-bit offset-binary mantissa, slots 13-15 carry the 3-bit exponent.
package jtopl_dac_pkg;
    localparam int unsigned MANTW       = 10;
    localparam int unsigned EXPW        = 3;
    localparam int unsigned FRAME_SLOTS = 16;
    localparam int unsigned SLOTW       = $clog2(FRAME_SLOTS);
    localparam int unsigned MANT_LO     = 3;
    localparam int unsigned EXP_LO      = 13;
    localparam int unsigned SH_START    = 13;
endpackage

// File: rtl/jtopl_dac_float.sv
// Combinational encoder from a signed linear sample to the YM3014-style
// floating-point word.
//   snd_i  : signed input sample, INW bits (INW >= 10)
//   exp_o  : exponent 1..7
//   mant_o : 10-bit mantissa, offset binary (MSB inverted)
module jtopl_dac_float
    import jtopl_dac_pkg::*;
#(
    parameter int INW = 16
) (
    input  logic [INW-1:0]   snd_i,
    output logic [EXPW-1:0]  exp_o,
    output logic [MANTW-1:0] mant_o
);

    logic signed [15:0] s16;
    logic signed [15:0] t;

    // Bring the sample to exactly 16 bits: saturate wider inputs, sign-extend narrower ones.
    generate
        if (INW > 16) begin : g_sat
            logic ovf;
            assign ovf = (snd_i[INW-1:15] != {(INW-15){snd_i[INW-1]}});
            assign s16 = ovf ? {snd_i[INW-1], {15{~snd_i[INW-1]}}} : snd_i[15:0];
        end else if (INW == 16) begin : g_pass
            assign s16 = snd_i;
        end else begin : g_ext
            assign s16 = {{(16-INW){snd_i[INW-1]}}, snd_i};
        end
    endgenerate

    // Walk shifts from largest to smallest; the last one that still fits in
    // signed 10 bits is the smallest exponent. A shift of 6 always fits.
    always_comb begin
        exp_o  = EXPW'(7);
        mant_o = '0;
        t      = '0;
        for (int k = 6; k >= 0; k--) begin
            t = s16 >>> k;
            if (t[15:9] == {7{t[9]}}) begin
                exp_o  = EXPW'(k + 1);
                mant_o = {~t[9], t[8:0]};
            end
        end
    end

endmodule

// File: rtl/jtopl_dac_serial.sv
// Serial transmitter for a YM3014-style floating-point DAC.
// Free-running framer: 16 slots of 2 cen each; every frame re-sends the
// latest captured sample.
//   clk, rst     : clock, synchronous active-high reset
//   cen          : clock enable, one cen = half a bit period
//   snd, snd_en  : signed sample and its capture strobe (qualified by cen)
//   dac_clk      : bit clock (equals the half-bit phase)
//   dac_so       : serial data, LSB first, changes on dac_clk falling
//   dac_sh       : latch strobe, high during slots 13-15, falls at frame boundary
//   ovr          : one-clk pulse when an unframed held sample is overwritten
module jtopl_dac_serial #(
    parameter int INW   = 16,
    parameter int MANTW = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic [INW-1:0] snd,
    input  logic           snd_en,
    output logic           dac_clk,
    output logic           dac_so,
    output logic           dac_sh,
    output logic           ovr
);
    import jtopl_dac_pkg::*;

    logic [SLOTW-1:0]       slot_q, slot_d;
    logic                   phase_q, phase_d;
    logic [INW-1:0]         hold_q, hold_d;
    logic                   hold_new_q, hold_new_d;
    logic [FRAME_SLOTS-1:0] sr_q, sr_d;
    logic                   so_q, so_d;
    logic                   sh_q, sh_d;
    logic                   ovr_q, ovr_d;

    logic                   boundary;
    logic [INW-1:0]         conv_in;
    logic [EXPW-1:0]        expo;
    logic [MANTW-1:0]       mant;
    logic [FRAME_SLOTS-1:0] word;

    assign boundary = cen && phase_q && (slot_q == SLOTW'(FRAME_SLOTS - 1));
    // A strobe in the boundary cycle bypasses hold so the newest sample wins.
    assign conv_in  = snd_en ? snd : hold_q;

    jtopl_dac_float #(
        .INW(INW)
    ) u_float (
        .snd_i (conv_in),
        .exp_o (expo),
        .mant_o(mant)
    );

    always_comb begin
        word                      = '0;
        word[MANT_LO +: MANTW]    = mant;
        word[EXP_LO +: EXPW]      = expo;
    end

    always_comb begin
        slot_d     = slot_q;
        phase_d    = phase_q;
        hold_d     = hold_q;
        hold_new_d = hold_new_q;
        sr_d       = sr_q;
        so_d       = so_q;
        sh_d       = sh_q;
        ovr_d      = 1'b0;
        if (cen) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                // dac_clk falling: next slot, next bit
                slot_d = slot_q + 1'b1;
                if (boundary) begin
                    so_d       = word[0];
                    sr_d       = word >> 1;
                    sh_d       = 1'b0;
                    hold_new_d = 1'b0;
                    if (snd_en) hold_d = snd;
                end else begin
                    so_d = sr_q[0];
                    sr_d = sr_q >> 1;
                    if (slot_q == SLOTW'(SH_START - 1)) sh_d = 1'b1;
                end
            end
            if (snd_en && !boundary) begin
                hold_d     = snd;
                hold_new_d = 1'b1;
                ovr_d      = hold_new_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            phase_q    <= 1'b0;
            hold_q     <= '0;
            hold_new_q <= 1'b0;
            sr_q       <= '0;
            so_q       <= 1'b0;
            sh_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            hold_new_q <= hold_new_d;
            sr_q       <= sr_d;
            so_q       <= so_d;
            sh_q       <= sh_d;
            ovr_q      <= ovr_d;
        end
    end

    assign dac_clk = phase_q;
    assign dac_so  = so_q;
    assign dac_sh  = sh_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_jtopl_dac_serial.sv
// Bench for jtopl_dac_serial: behavioural frame model compared every cycle,
// DAC-side receiver capturing words on dac_sh falling, literal word checks.
module tb_jtopl_dac_serial;

    logic        clk = 1'b0;
    logic        rst, cen, snd_en;
    logic [15:0] snd;
    logic        dac_clk, dac_so, dac_sh, ovr;

    jtopl_dac_serial #(
        .INW  (16),
        .MANTW(10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .snd    (snd),
        .snd_en (snd_en),
        .dac_clk(dac_clk),
        .dac_so (dac_so),
        .dac_sh (dac_sh),
        .ovr    (ovr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: frame word = {exp[2:0], mant^0x200, 3'b000}
    function automatic logic [15:0] enc(input logic [15:0] s);
        int v, e, t;
        logic [9:0] m;
        bit found;
        found = 0; e = 7; v = 0;
        for (int k = 1; k <= 7; k++) begin
            t = int'($signed(s)) >>> (k - 1);
            if (!found && t >= -512 && t <= 511) begin
                found = 1; e = k; v = t;
            end
        end
        m = v[9:0] ^ 10'h200;
        return {e[2:0], m, 3'b000};
    endfunction

    // Model: count of cen since reset gives position in frame; the word on
    // the wire is whichever sample was latest at the last frame boundary.
    int          m_cnt = 0;
    logic [15:0] m_word = '0;
    logic [15:0] m_hold = '0;
    bit          m_new = 0;
    bit          m_ovr = 0;
    bit          started = 0;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_cnt = 0; m_word = '0; m_hold = '0; m_new = 0; m_ovr = 0;
        end else begin
            m_ovr = 0;
            if (cen) begin
                if (snd_en) begin
                    if (m_cnt % 32 == 31) begin
                        m_hold = snd; m_new = 0;
                    end else begin
                        if (m_new) m_ovr = 1;
                        m_hold = snd; m_new = 1;
                    end
                end
                if (m_cnt % 32 == 31) begin
                    m_word = enc(m_hold);
                    m_new  = 0;
                end
                m_cnt++;
            end
        end
    end

    // DAC-side receiver
    logic [15:0] rx = '0;
    logic [15:0] last_latch = '0;
    int          latch_cnt = 0;
    int          cyc = 0;
    int          latch_cyc = 0;
    int          latch_cyc_prev = 0;
    int          ovr_cnt = 0;
    logic        prev_clk = 1'b0;
    logic        prev_sh = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (dac_clk === 1'b1 && prev_clk === 1'b0) rx = {dac_so, rx[15:1]};
        if (dac_sh === 1'b0 && prev_sh === 1'b1) begin
            last_latch = rx;
            latch_cnt++;
            latch_cyc_prev = latch_cyc;
            latch_cyc = cyc;
        end
        if (ovr === 1'b1) ovr_cnt++;
        prev_clk = dac_clk;
        prev_sh  = dac_sh;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then step to just after posedge.
    task automatic tick();
        int   slot;
        logic [3:0] exp4;
        @(negedge clk);
        if (started) begin
            slot = (m_cnt % 32) / 2;
            exp4 = {1'(m_cnt % 2), m_word[slot], 1'(slot >= 13), m_ovr};
            check("cycle{clk,so,sh,ovr}", {12'b0, dac_clk, dac_so, dac_sh, ovr}, {12'b0, exp4});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        bit done;
        done = (m_cnt % 32 == p);
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            done = (m_cnt % 32 == p);
        end
        if (!done) check("wait_pos_timeout", 16'd0, 16'd1);
    endtask

    task automatic pulse(input logic [15:0] v);
        snd = v; snd_en = 1'b1;
        tick();
        snd_en = 1'b0;
    endtask

    task automatic wait_latches(input int n, output logic [15:0] w);
        int  base;
        bit  done;
        base = latch_cnt;
        done = 0;
        for (int i = 0; i < 40 * n && !done; i++) begin
            tick();
            done = (latch_cnt >= base + n);
        end
        if (!done) check("wait_latch_timeout", 16'd0, 16'd1);
        w = last_latch;
    endtask

    task automatic frame_at_boundary(input string name, input logic [15:0] v,
                                     input logic [15:0] expw);
        logic [15:0] w;
        wait_pos(31);
        pulse(v);
        wait_latches(2, w);
        check(name, w, expw);
    endtask

    initial begin
        logic [15:0] w;
        int          base_ovr;

        rst = 1'b1; cen = 1'b0; snd_en = 1'b0; snd = '0;
        repeat (3) tick();
        check("reset_outputs", {12'b0, dac_clk, dac_so, dac_sh, ovr}, 16'h0);
        rst = 1'b0; cen = 1'b1;

        // First loaded frame after reset carries sample 0
        wait_latches(2, w);
        check("first_frame_zero", w, 16'h3000);

        // Pin the encoder with hand-computed words
        frame_at_boundary("snd_100", 16'd100, 16'h3320);
        frame_at_boundary("snd_1000", 16'd1000, 16'h5FA0);
        frame_at_boundary("snd_m32768", 16'h8000, 16'hE000);
        frame_at_boundary("snd_32767", 16'h7FFF, 16'hFFF8);

        // Two strobes inside one frame: one ovr, later one wins
        base_ovr = ovr_cnt;
        wait_pos(5);
        pulse(16'h0100);
        wait_pos(15);
        pulse(16'h0200);
        wait_latches(2, w);
        check("overwrite_ovr_count", 16'(ovr_cnt - base_ovr), 16'd1);
        check("overwrite_word", w, 16'h5800);

        // Strobe at boundary with a pending sample: new wins, no ovr
        base_ovr = ovr_cnt;
        wait_pos(10);
        pulse(16'd50);
        wait_pos(31);
        pulse(16'hFFFF);
        wait_latches(2, w);
        check("coincident_word", w, 16'h2FF8);
        check("coincident_no_ovr", 16'(ovr_cnt - base_ovr), 16'd0);

        // Idle frames repeat -1 every 32 cen
        for (int i = 0; i < 3; i++) begin
            wait_latches(1, w);
            check("repeat_word", w, 16'h2FF8);
            check("repeat_interval", 16'(latch_cyc - latch_cyc_prev), 16'd32);
        end

        // hold_new was cleared at the coincident boundary: a lone strobe gives no ovr
        base_ovr = ovr_cnt;
        wait_pos(10);
        pulse(16'd7);
        repeat (3) tick();
        check("single_strobe_no_ovr", 16'(ovr_cnt - base_ovr), 16'd0);

        // Reset mid-frame at slot 7
        wait_pos(14);
        rst = 1'b1;
        tick();
        check("midreset_outputs", {12'b0, dac_clk, dac_so, dac_sh, ovr}, 16'h0);
        rst = 1'b0;
        wait_latches(2, w);
        check("post_reset_frame", w, 16'h3000);

        // cen low: everything frozen (model holds too)
        wait_pos(27);
        cen = 1'b0;
        snd = 16'h1234; snd_en = 1'b1;
        repeat (8) tick();
        snd_en = 1'b0;
        cen = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cen    = ($urandom % 4) != 0;
            snd_en = ($urandom % 12) == 0;
            case ($urandom % 6)
                0: snd = 16'h8000;
                1: snd = 16'h7FFF;
                2: snd = 16'($urandom_range(0, 1023)) - 16'd512;
                default: snd = 16'($urandom);
            endcase
            rst = ($urandom % 700) == 0;
            tick();
        end
        rst = 1'b0; snd_en = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jtopl_dac_serial.md
Name: jtopl_dac_serial

Overview:
- Transmit side of the chip's sound output path. Takes the saturated signed sample produced once per sample period by the channel accumulator.
- Converts it to the YM3014-style floating-point word: 10-bit offset-binary mantissa plus 3-bit exponent.
- Shifts the word out serially, LSB first, with bit clock and latch strobe, so an external floating-point DAC or its model can rebuild the audio.
- Free-running framer: frames repeat continuously and each frame re-sends the latest sample.

Parameters:
INW, 16, width of signed input sample (must be >= 10)
MANTW, 10, mantissa width (fixed by DAC format; not to be overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cen  in  1  clock enable; one cen = one half bit period
snd  in  INW  signed sample from accumulator
snd_en  in  1  strobe, qualified by cen; snd is valid in this cycle
dac_clk  out  1  serial bit clock
dac_so  out  1  serial data
dac_sh  out  1  latch strobe; DAC latches word on falling edge
ovr  out  1  one-cycle pulse: held sample overwritten before being framed

Behaviour:
- Reset (rst high at clk edge, cen ignored): dac_clk=0, dac_so=0, dac_sh=0, ovr=0, slot=0, phase=0, hold=0, hold_new=0, shift reg=0.
- Mid-operation reset aborts the frame; the first frame after reset sends sample 0 (mantissa 0x200, exp 1).
- All state advances only on cycles with cen=1, except rst and the ovr clear.
- Phase toggles each cen, giving dac_clk = phase. One bit slot = 2 cen; 16 slots per frame = 32 cen.
- Slot counter 0..15 increments when phase goes 1->0 and wraps 15->0. This is the frame boundary.
- Input capture: snd_en&cen writes hold<=snd and sets hold_new.
  - If hold_new is already set and the capture is not in the frame-boundary cycle, ovr pulses for one clk.
- Frame boundary cycle (slot 15, phase 1->0, cen):
  - The shift register loads the conversion of hold; hold_new clears.
  - If snd_en arrives in the same cycle, the new snd bypasses hold and is framed directly: new sample wins. No ovr, and hold_new stays 0.
- Conversion (combinational on the value being loaded):
  - exp e = smallest value in 1..7 such that snd >>> (e-1) fits in signed 10 bits. For INW>16, saturate to 16 bits first.
  - mantissa m = (snd >>> (e-1))[9:0] with MSB inverted (offset binary). Truncation is toward -inf.
- Frame layout: slots 0-2 = 0, slots 3-12 = m[0..9], slots 13-15 = e[0..2].
  - dac_so changes only on phase 1->0 (dac_clk falling) and is stable while dac_clk is high.
- dac_sh rises entering slot 13 and falls at the frame boundary. The latched word takes effect with that falling edge.
- Latency: a sample strobed at the frame boundary appears on dac_so starting 0 cen later (slot 0). Mantissa LSB starts at cen 6 after the boundary.
- No new sample in a frame: previous hold is re-sent unchanged.

Decomposition:
- Package jtopl_dac_pkg: MANTW=10, EXPW=3, FRAME_SLOTS=16, slot indices MANT_LO=3, EXP_LO=13, SH_START=13.
- One sub-module, jtopl_dac_float: combinational INW->{e,m} encoder, separately testable. The framing and shift logic stays in the top module.

Test Plan:
- snd=100 at boundary -> e=1, m=0x264; dac_so slots 3-12 = 0,0,1,0,0,1,1,0,0,1; slots 13-15 = 1,0,0.
- snd=1000 -> e=2, m=0x3F4. snd=-32768 -> e=7, m=0x000. snd=32767 -> e=7, m=0x3FF. Check via dac_sh falling-edge capture.
- Two snd_en strobes inside one frame (0x0100 then 0x0200) -> one ovr pulse; next frame carries 0x0200 (e=1, m=0x000 MSB-inverted => 0x200^0x200... m=0x200 sent as 0x000? No: 512 overflows 10-bit signed, so e=2, m=0x300).
- snd_en coincident with the frame boundary while hold_new=1 -> new value framed, ovr stays 0, hold_new=0.
- No snd_en for 3 frames after snd=-1 -> each frame sends e=1, m=0x1FF, and dac_sh falls every 32 cen.
- rst asserted at slot 7 -> next clk all outputs 0; the next frame sends e=1, m=0x200; cen held low -> outputs frozen.
